// File: rtl/multu_seq_if.sv
// Start/busy/done handshake and operand/product bus for the sequential MULTU unit.
interface multu_seq_if #(parameter int WIDTH = 32);
  logic                 start;
  logic [WIDTH-1:0]     dataA;
  logic [WIDTH-1:0]     dataB;
  logic                 busy;
  logic                 done;
  logic [2*WIDTH-1:0]   dataOut;

  modport master (output start, dataA, dataB, input busy, done, dataOut);
  modport slave  (input start, dataA, dataB, output busy, done, dataOut);
endinterface

// File: rtl/multu_seq.sv
// Sequential unsigned shift-add multiplier for the HI/LO path, one partial product per clock.
// MULT_ZERO_BYPASS_EN: a zero operand completes on the accepting edge without entering RUN.
module multu_seq #(
  parameter int WIDTH = 32
) (
  input  logic        clk,
  input  logic        reset,
  multu_seq_if.slave  bus
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t               r_state;
  logic [2*WIDTH:0]     r_acc;
  logic [WIDTH-1:0]     r_mcand;
  logic [CW-1:0]        r_cnt;
  logic                 r_busy;
  logic                 r_done;
  logic [2*WIDTH-1:0]   r_data_out;

  logic [WIDTH:0]       w_upper;
  logic [2*WIDTH:0]     w_acc_next;
  logic                 w_zero;

  // 33-bit partial sum keeps the carry so the full 64-bit product is exact
  assign w_upper    = r_acc[0] ? ({1'b0, r_acc[2*WIDTH-1:WIDTH]} + {1'b0, r_mcand})
                               : r_acc[2*WIDTH:WIDTH];
  assign w_acc_next = {w_upper, r_acc[WIDTH-1:0]} >> 1;

`ifdef MULT_ZERO_BYPASS_EN
  assign w_zero = (bus.dataA == '0) || (bus.dataB == '0);
`else
  assign w_zero = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_acc      <= '0;
      r_mcand    <= '0;
      r_cnt      <= '0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_data_out <= '0;
    end else begin
      case (r_state)
        S_IDLE, S_DONE: begin
          r_done <= 1'b0;
          if (bus.start) begin
            r_mcand <= bus.dataA;
            r_acc   <= {{(WIDTH+1){1'b0}}, bus.dataB};
            r_cnt   <= '0;
            if (w_zero) begin
              r_data_out <= '0;
              r_done     <= 1'b1;
              r_state    <= S_DONE;
            end else begin
              r_busy  <= 1'b1;
              r_state <= S_RUN;
            end
          end else begin
            r_state <= S_IDLE;
          end
        end
        S_RUN: begin
          r_acc <= w_acc_next;
          r_cnt <= r_cnt + 1'b1;
          if (r_cnt == LAST) begin
            r_data_out <= w_acc_next[2*WIDTH-1:0];
            r_busy     <= 1'b0;
            r_done     <= 1'b1;
            r_state    <= S_DONE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.busy    = r_busy;
  assign bus.done    = r_done;
  assign bus.dataOut = r_data_out;

endmodule

// File: tb/tb_multu_seq.sv
// Directed self-checking bench for multu_seq: latency, results, busy/done handshake, reset.
module tb_multu_seq;

  logic clk;
  logic reset;
  int   pass_cnt;
  int   total_cnt;

  multu_seq_if #(.WIDTH(32)) bus ();

  multu_seq #(.WIDTH(32)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

`ifdef MULT_ZERO_BYPASS_EN
  localparam int ZERO_LAT  = 0;
  localparam int ZERO_BUSY = 0;
`else
  localparam int ZERO_LAT  = 32;
  localparam int ZERO_BUSY = 32;
`endif

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Called right after the accepting edge; n = edges until done is visible, -1 on timeout
  task automatic wait_done(output int n, output int bc, output bit ov, output bit chg);
    logic [63:0] d0;
    d0  = bus.dataOut;
    n   = 0;
    bc  = 0;
    ov  = 1'b0;
    chg = 1'b0;
    while (!bus.done && n < 40) begin
      if (bus.busy) bc++;
      if (bus.dataOut !== d0) chg = 1'b1;
      tick();
      n++;
    end
    if (!bus.done) n = -1;
    if (bus.busy && bus.done) ov = 1'b1;
  endtask

  task automatic start_op(input logic [31:0] a, input logic [31:0] b);
    bus.start = 1'b1;
    bus.dataA = a;
    bus.dataB = b;
    tick();
    bus.start = 1'b0;
  endtask

  task automatic test_reset();
    reset     = 1'b1;
    bus.start = 1'b0;
    bus.dataA = '0;
    bus.dataB = '0;
    tick();
    tick();
    reset = 1'b0;
    total_cnt++;
    if (bus.busy !== 1'b0) $display("FAIL reset_busy got %b exp 0", bus.busy); else pass_cnt++;
    total_cnt++;
    if (bus.done !== 1'b0) $display("FAIL reset_done got %b exp 0", bus.done); else pass_cnt++;
    total_cnt++;
    if (bus.dataOut !== 64'h0) $display("FAIL reset_dataOut got %h exp 0", bus.dataOut); else pass_cnt++;
  endtask

  task automatic test_basic();
    int n, bc; bit ov, chg;
    start_op(32'd3, 32'd5);
    wait_done(n, bc, ov, chg);
    total_cnt++;
    if (n !== 32) $display("FAIL basic_latency got %0d exp 32", n); else pass_cnt++;
    total_cnt++;
    if (bc !== 32) $display("FAIL basic_busy_cycles got %0d exp 32", bc); else pass_cnt++;
    total_cnt++;
    if (ov !== 1'b0) $display("FAIL basic_busy_done_overlap got %b exp 0", ov); else pass_cnt++;
    total_cnt++;
    if (bus.dataOut !== 64'h0000_0000_0000_000F)
      $display("FAIL basic_product got %h exp 000000000000000f", bus.dataOut); else pass_cnt++;
    tick();
    total_cnt++;
    if (bus.done !== 1'b0) $display("FAIL basic_done_pulse got %b exp 0", bus.done); else pass_cnt++;
    total_cnt++;
    if (bus.dataOut !== 64'h0000_0000_0000_000F)
      $display("FAIL basic_hold got %h exp 000000000000000f", bus.dataOut); else pass_cnt++;
  endtask

  task automatic test_max();
    int n, bc; bit ov, chg;
    start_op(32'hFFFF_FFFF, 32'hFFFF_FFFF);
    wait_done(n, bc, ov, chg);
    total_cnt++;
    if (n !== 32) $display("FAIL max_latency got %0d exp 32", n); else pass_cnt++;
    total_cnt++;
    if (bus.dataOut !== 64'hFFFF_FFFE_0000_0001)
      $display("FAIL max_product got %h exp fffffffe00000001", bus.dataOut); else pass_cnt++;
    tick();
    start_op(32'h8000_0000, 32'd2);
    wait_done(n, bc, ov, chg);
    total_cnt++;
    if (bus.dataOut !== 64'h0000_0001_0000_0000)
      $display("FAIL msb_x2_product got %h exp 0000000100000000", bus.dataOut); else pass_cnt++;
    tick();
  endtask

  task automatic test_ignore_busy();
    int n, bc, extra; bit ov, chg;
    start_op(32'd7, 32'd9);
    for (int i = 0; i < 9; i++) tick();
    bus.start = 1'b1;
    bus.dataA = 32'd100;
    bus.dataB = 32'd100;
    tick();
    bus.start = 1'b0;
    wait_done(n, bc, ov, chg);
    total_cnt++;
    if (n !== 22) $display("FAIL ignore_latency got %0d exp 22", n); else pass_cnt++;
    total_cnt++;
    if (bus.dataOut !== 64'd63) $display("FAIL ignore_product got %0d exp 63", bus.dataOut); else pass_cnt++;
    extra = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (bus.done || bus.busy) extra++;
    end
    total_cnt++;
    if (extra !== 0) $display("FAIL ignore_no_second_op got %0d active cycles exp 0", extra); else pass_cnt++;
  endtask

  task automatic test_back_to_back();
    int n, bc; bit ov, chg;
    bus.start = 1'b1;
    bus.dataA = 32'd2;
    bus.dataB = 32'd3;
    tick();
    bus.dataA = 32'd4;
    bus.dataB = 32'd5;
    wait_done(n, bc, ov, chg);
    total_cnt++;
    if (n !== 32) $display("FAIL b2b_first_latency got %0d exp 32", n); else pass_cnt++;
    total_cnt++;
    if (bus.dataOut !== 64'd6) $display("FAIL b2b_first_product got %0d exp 6", bus.dataOut); else pass_cnt++;
    tick();
    bus.start = 1'b0;
    total_cnt++;
    if (bus.busy !== 1'b1 || bus.done !== 1'b0)
      $display("FAIL b2b_restart got busy=%b done=%b exp busy=1 done=0", bus.busy, bus.done); else pass_cnt++;
    wait_done(n, bc, ov, chg);
    total_cnt++;
    if (n !== 32) $display("FAIL b2b_second_latency got %0d exp 32", n); else pass_cnt++;
    total_cnt++;
    if (chg !== 1'b0) $display("FAIL b2b_hold_during_run got changed=%b exp 0", chg); else pass_cnt++;
    total_cnt++;
    if (bus.dataOut !== 64'd20) $display("FAIL b2b_second_product got %0d exp 20", bus.dataOut); else pass_cnt++;
    tick();
  endtask

  task automatic test_reset_mid();
    int n, bc; bit ov, chg;
    start_op(32'd12345, 32'd6789);
    for (int i = 0; i < 15; i++) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    total_cnt++;
    if (bus.busy !== 1'b0 || bus.done !== 1'b0)
      $display("FAIL midreset_flags got busy=%b done=%b exp 0 0", bus.busy, bus.done); else pass_cnt++;
    total_cnt++;
    if (bus.dataOut !== 64'h0) $display("FAIL midreset_dataOut got %h exp 0", bus.dataOut); else pass_cnt++;
    start_op(32'd2, 32'd2);
    wait_done(n, bc, ov, chg);
    total_cnt++;
    if (n !== 32) $display("FAIL midreset_after_latency got %0d exp 32", n); else pass_cnt++;
    total_cnt++;
    if (bus.dataOut !== 64'd4) $display("FAIL midreset_after_product got %0d exp 4", bus.dataOut); else pass_cnt++;
    tick();
  endtask

  task automatic test_reset_with_start();
    reset     = 1'b1;
    bus.start = 1'b1;
    bus.dataA = 32'd3;
    bus.dataB = 32'd3;
    tick();
    reset     = 1'b0;
    bus.start = 1'b0;
    tick();
    total_cnt++;
    if (bus.busy !== 1'b0 || bus.done !== 1'b0)
      $display("FAIL reset_beats_start got busy=%b done=%b exp 0 0", bus.busy, bus.done); else pass_cnt++;
  endtask

  task automatic test_zero();
    int n, bc; bit ov, chg;
    start_op(32'd6, 32'd7);
    wait_done(n, bc, ov, chg);
    total_cnt++;
    if (bus.dataOut !== 64'd42) $display("FAIL zero_setup_product got %0d exp 42", bus.dataOut); else pass_cnt++;
    tick();
    start_op(32'd0, 32'hDEAD_BEEF);
    wait_done(n, bc, ov, chg);
    total_cnt++;
    if (n !== ZERO_LAT) $display("FAIL zero_latency got %0d exp %0d", n, ZERO_LAT); else pass_cnt++;
    total_cnt++;
    if (bc !== ZERO_BUSY) $display("FAIL zero_busy_cycles got %0d exp %0d", bc, ZERO_BUSY); else pass_cnt++;
    total_cnt++;
    if (bus.dataOut !== 64'h0) $display("FAIL zero_product got %h exp 0", bus.dataOut); else pass_cnt++;
    tick();
  endtask

  initial begin
    pass_cnt  = 0;
    total_cnt = 0;
    reset     = 1'b1;
    bus.start = 1'b0;
    bus.dataA = '0;
    bus.dataB = '0;
    test_reset();
    test_basic();
    test_max();
    test_ignore_busy();
    test_back_to_back();
    test_reset_mid();
    test_reset_with_start();
    test_zero();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
